// File: rtl/noise_est_frame_sequencer_if.sv
// Bus bundle between noise_est_frame_sequencer and its pixel memory / noise
// estimator. The master modport is the sequencer side; the slave modport is
// the memory-plus-estimator side.
//
// Handshake semantics: mem_rd_en is a request strobe with no back-pressure;
// mem_rd_data must be valid exactly one cycle after each mem_rd_en.
// ne_start_of_frame and ne_start_data are single-cycle framing strobes.
// ne_estimated_noise_ready is a single-cycle valid that qualifies
// ne_estimated_noise. There is no ready signal in either direction, so a
// strobe is consumed in the cycle it is high.
interface noise_est_frame_sequencer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
);
  logic                    mem_rd_en;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_rd_data;
  logic                    ne_start_of_frame;
  logic                    ne_start_data;
  logic [DATA_WIDTH-1:0]   ne_data_in;
  logic [31:0]             ne_blocks_per_frame;
  logic [2*DATA_WIDTH-1:0] ne_estimated_noise;
  logic                    ne_estimated_noise_ready;

  modport master (
    output mem_rd_en, mem_addr,
    input  mem_rd_data,
    output ne_start_of_frame, ne_start_data, ne_data_in, ne_blocks_per_frame,
    input  ne_estimated_noise, ne_estimated_noise_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr,
    output mem_rd_data,
    input  ne_start_of_frame, ne_start_data, ne_data_in, ne_blocks_per_frame,
    output ne_estimated_noise, ne_estimated_noise_ready
  );
endinterface

// File: rtl/noise_est_frame_sequencer.sv
// noise_est_frame_sequencer: frame-level controller for the noise estimator.
// On an accepted start it streams cfg_blocks_per_frame blocks of
// TOTAL_SAMPLES pixels from memory to the estimator, each block preceded by
// BLOCK_GAP idle cycles, then waits for the estimator result and returns it
// to the host with a one-cycle noise_valid strobe.
// Optional feature macro: NE_SEQ_TIMEOUT_EN adds TIMEOUT_CYCLES and the
// timeout_err output; without it the result wait is unbounded.
// All outputs are registered; dbg_state exposes the FSM state.
module noise_est_frame_sequencer #(
  parameter int DATA_WIDTH    = 8,
  parameter int TOTAL_SAMPLES = 64,
  parameter int ADDR_WIDTH    = 16,
  parameter int BLOCK_GAP     = 2
`ifdef NE_SEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 4096
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [31:0]             cfg_blocks_per_frame,
  output logic                    busy,
  output logic                    done,
  output logic                    cfg_error,
  output logic [2*DATA_WIDTH-1:0] noise_out,
  output logic                    noise_valid,
`ifdef NE_SEQ_TIMEOUT_EN
  output logic                    timeout_err,
`endif
  output logic [2:0]              dbg_state,
  noise_est_frame_sequencer_if.master bus
);

  localparam int SW = $clog2(TOTAL_SAMPLES + 1);
  localparam int GW = $clog2(BLOCK_GAP + 1);
  localparam logic [SW-1:0] S_LAST   = SW'(TOTAL_SAMPLES);
  localparam logic [GW-1:0] GAP_LAST = GW'(BLOCK_GAP - 1);
`ifdef NE_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    GAP      = 3'd2,
    STREAM   = 3'd3,
    WAIT_RES = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [GW-1:0]           gap_cnt_q, gap_cnt_d;
  logic [SW-1:0]           samp_cnt_q, samp_cnt_d;
  logic [31:0]             block_cnt_q, block_cnt_d;
  logic [31:0]             blocks_q, blocks_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    rd_en_q, rd_en_d;
  logic                    sof_q, sof_d;
  logic                    sd_q, sd_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    cfg_err_q, cfg_err_d;
  logic [2*DATA_WIDTH-1:0] noise_q, noise_d;
  logic                    noise_valid_q, noise_valid_d;
`ifdef NE_SEQ_TIMEOUT_EN
  logic [TW-1:0]           to_cnt_q, to_cnt_d;
  logic                    to_err_q, to_err_d;
`endif

  // Next-state and next-output computation for the frame FSM.
  always_comb begin
    state_d       = state_q;
    gap_cnt_d     = gap_cnt_q;
    samp_cnt_d    = samp_cnt_q;
    block_cnt_d   = block_cnt_q;
    blocks_d      = blocks_q;
    addr_d        = addr_q;
    noise_d       = noise_q;
    cfg_err_d     = 1'b0;
    noise_valid_d = 1'b0;
`ifdef NE_SEQ_TIMEOUT_EN
    to_cnt_d      = to_cnt_q;
    to_err_d      = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_blocks_per_frame != 32'd0) begin
            state_d     = LOAD;
            blocks_d    = cfg_blocks_per_frame;
            block_cnt_d = 32'd0;
            addr_d      = '0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        state_d   = GAP;
        gap_cnt_d = '0;
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d    = STREAM;
          samp_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      STREAM: begin
        if (samp_cnt_q != S_LAST) begin
          // A read is issued this cycle; advance to the next pixel.
          addr_d     = addr_q + ADDR_WIDTH'(1);
          samp_cnt_d = samp_cnt_q + SW'(1);
        end else begin
          // Final beat of the block.
          block_cnt_d = block_cnt_q + 32'd1;
          gap_cnt_d   = '0;
          if (({1'b0, block_cnt_q} + 33'd1) < {1'b0, blocks_q}) begin
            state_d = GAP;
          end else begin
            state_d = WAIT_RES;
`ifdef NE_SEQ_TIMEOUT_EN
            to_cnt_d = '0;
`endif
          end
        end
      end
      WAIT_RES: begin
        if (bus.ne_estimated_noise_ready) begin
          noise_d       = bus.ne_estimated_noise;
          noise_valid_d = 1'b1;
          state_d       = DONE;
        end
`ifdef NE_SEQ_TIMEOUT_EN
        else if (to_cnt_q == TO_LAST) begin
          to_err_d = 1'b1;
          state_d  = DONE;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered, so derive them from the state being entered.
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    rd_en_d = (state_d == STREAM) && (samp_cnt_d != S_LAST);
    // The first beat of a block appears one cycle after sample 0 is read.
    sd_d    = (state_q == STREAM) && (samp_cnt_q == '0);
    sof_d   = sd_d && (block_cnt_q == 32'd0);
  end

  // Single state register for the FSM, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      gap_cnt_q     <= '0;
      samp_cnt_q    <= '0;
      block_cnt_q   <= '0;
      blocks_q      <= '0;
      addr_q        <= '0;
      rd_en_q       <= 1'b0;
      sof_q         <= 1'b0;
      sd_q          <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      cfg_err_q     <= 1'b0;
      noise_q       <= '0;
      noise_valid_q <= 1'b0;
`ifdef NE_SEQ_TIMEOUT_EN
      to_cnt_q      <= '0;
      to_err_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      gap_cnt_q     <= gap_cnt_d;
      samp_cnt_q    <= samp_cnt_d;
      block_cnt_q   <= block_cnt_d;
      blocks_q      <= blocks_d;
      addr_q        <= addr_d;
      rd_en_q       <= rd_en_d;
      sof_q         <= sof_d;
      sd_q          <= sd_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      cfg_err_q     <= cfg_err_d;
      noise_q       <= noise_d;
      noise_valid_q <= noise_valid_d;
`ifdef NE_SEQ_TIMEOUT_EN
      to_cnt_q      <= to_cnt_d;
      to_err_q      <= to_err_d;
`endif
    end
  end

  assign busy                    = busy_q;
  assign done                    = done_q;
  assign cfg_error               = cfg_err_q;
  assign noise_out               = noise_q;
  assign noise_valid             = noise_valid_q;
  assign dbg_state               = state_q;
  assign bus.mem_rd_en           = rd_en_q;
  assign bus.mem_addr            = addr_q;
  assign bus.ne_start_of_frame   = sof_q;
  assign bus.ne_start_data       = sd_q;
  assign bus.ne_blocks_per_frame = blocks_q;
  // Pixel data goes straight through to the estimator.
  assign bus.ne_data_in          = bus.mem_rd_data;
`ifdef NE_SEQ_TIMEOUT_EN
  assign timeout_err             = to_err_q;
`endif

endmodule

// File: tb/tb_noise_est_frame_sequencer.sv
// Directed bench for noise_est_frame_sequencer with TOTAL_SAMPLES=4,
// BLOCK_GAP=2 and memory word[a] = 4*a. A second instance with ADDR_WIDTH=3
// covers the address wrap.
module tb_noise_est_frame_sequencer;
  localparam int TS    = 4;
  localparam int GAP   = 2;
  localparam int PER   = TS + 1 + GAP;  // cycles from one block's first read to the next
  localparam int FIRST = 2 + GAP;       // start-to-first-read latency

  logic clk = 1'b0;
  logic rst;
  logic start0, start1;
  logic [31:0] cfg0, cfg1;
  logic busy0, done0, cfg_err0, nv0, busy1, done1, cfg_err1, nv1;
  logic [15:0] noise0, noise1;
  logic [2:0] dbg0, dbg1;
`ifdef NE_SEQ_TIMEOUT_EN
  logic to_err0, to_err1;
`endif

  int checks = 0;
  int failures = 0;

  logic [15:0] exp_addr0[$];
  logic [7:0]  exp_data0[$];
  logic [15:0] exp_addr1[$];
  logic [7:0]  exp_data1[$];

  logic [7:0] mem0_q = 8'd0;
  logic [7:0] mem1_q = 8'd0;
  logic prev_rd0 = 1'b0;
  logic prev_rd1 = 1'b0;

  noise_est_frame_sequencer_if #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) bus0 ();
  noise_est_frame_sequencer_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3))  bus1 ();

  noise_est_frame_sequencer #(
    .DATA_WIDTH(8), .TOTAL_SAMPLES(TS), .ADDR_WIDTH(16), .BLOCK_GAP(GAP)
  ) u0 (
    .clk(clk), .rst(rst), .start(start0), .cfg_blocks_per_frame(cfg0),
    .busy(busy0), .done(done0), .cfg_error(cfg_err0),
    .noise_out(noise0), .noise_valid(nv0),
`ifdef NE_SEQ_TIMEOUT_EN
    .timeout_err(to_err0),
`endif
    .dbg_state(dbg0), .bus(bus0)
  );

  noise_est_frame_sequencer #(
    .DATA_WIDTH(8), .TOTAL_SAMPLES(TS), .ADDR_WIDTH(3), .BLOCK_GAP(GAP)
  ) u1 (
    .clk(clk), .rst(rst), .start(start1), .cfg_blocks_per_frame(cfg1),
    .busy(busy1), .done(done1), .cfg_error(cfg_err1),
    .noise_out(noise1), .noise_valid(nv1),
`ifdef NE_SEQ_TIMEOUT_EN
    .timeout_err(to_err1),
`endif
    .dbg_state(dbg1), .bus(bus1)
  );

  // Clock and pixel memories (read data one cycle after the request).
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus0.mem_rd_en) mem0_q <= 8'({bus0.mem_addr, 2'b00});
    if (bus1.mem_rd_en) mem1_q <= 8'({bus1.mem_addr, 2'b00});
  end

  assign bus0.mem_rd_data = mem0_q;
  assign bus1.mem_rd_data = mem1_q;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Timing model: reads, start_data and start_of_frame for a frame started at cycle 0.
  function automatic logic exp_rd(input int k, input int nblk);
    return (k >= FIRST) && (((k - FIRST) % PER) < TS) && (((k - FIRST) / PER) < nblk);
  endfunction

  function automatic logic exp_sd(input int k, input int nblk);
    return (k >= FIRST + 1) && (((k - FIRST - 1) % PER) == 0) && (((k - FIRST - 1) / PER) < nblk);
  endfunction

  function automatic int wait_cycle(input int nblk);
    return FIRST + PER * nblk - GAP;
  endfunction

  // Scoreboard: every read address and every data beat against the expected queues.
  always @(negedge clk) begin
    if (bus0.mem_rd_en) begin
      if (exp_addr0.size() == 0) check("addr0_extra_read", 1, 0);
      else check("addr0", bus0.mem_addr, exp_addr0.pop_front());
    end
    if (prev_rd0) begin
      if (exp_data0.size() == 0) check("data0_extra_beat", 1, 0);
      else check("data0", bus0.ne_data_in, exp_data0.pop_front());
    end
    prev_rd0 = bus0.mem_rd_en;
    if (bus1.mem_rd_en) begin
      if (exp_addr1.size() == 0) check("addr1_extra_read", 1, 0);
      else check("addr1", bus1.mem_addr, exp_addr1.pop_front());
    end
    if (prev_rd1) begin
      if (exp_data1.size() == 0) check("data1_extra_beat", 1, 0);
      else check("data1", bus1.ne_data_in, exp_data1.pop_front());
    end
    prev_rd1 = bus1.mem_rd_en;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; cfg0 = 32'd0; cfg1 = 32'd0;
    bus0.ne_estimated_noise = 16'h0; bus0.ne_estimated_noise_ready = 1'b0;
    bus1.ne_estimated_noise = 16'h0; bus1.ne_estimated_noise_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_cfg_error", cfg_err0, 0);
    check("rst_rd_en", bus0.mem_rd_en, 0);
    check("rst_addr", bus0.mem_addr, 0);
    check("rst_sof", bus0.ne_start_of_frame, 0);
    check("rst_sd", bus0.ne_start_data, 0);
    check("rst_blocks", bus0.ne_blocks_per_frame, 0);
    check("rst_noise", noise0, 0);
    check("rst_nv", nv0, 0);
    check("rst_state", dbg0, 0);
    check("rst_busy1", busy1, 0);
    rst = 1'b0;
    @(negedge clk);

    // Zero config: rejected with a single cfg_error pulse.
    start0 = 1'b1; cfg0 = 32'd0;
    @(negedge clk);
    start0 = 1'b0;
    check("zero_cfg_error", cfg_err0, 1);
    check("zero_busy", busy0, 0);
    @(negedge clk);
    check("zero_cfg_error_clr", cfg_err0, 0);
    check("zero_busy2", busy0, 0);
    check("zero_rd_en", bus0.mem_rd_en, 0);

    // Nominal 4-block frame with a mid-frame start and an early ready.
    for (int i = 0; i < 16; i++) begin
      exp_addr0.push_back(16'(i));
      exp_data0.push_back(8'(4 * i));
    end
    start0 = 1'b1; cfg0 = 32'd4;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      check("nom_rd_en", bus0.mem_rd_en, exp_rd(k, 4));
      check("nom_sd", bus0.ne_start_data, exp_sd(k, 4));
      check("nom_sof", bus0.ne_start_of_frame, k == FIRST + 1);
      check("nom_done", done0, k == 32);
      check("nom_nv", nv0, k == 32);
      check("nom_busy", busy0, k <= 32);
      if (k == 1) begin
        start0 = 1'b0;
        check("nom_blocks", bus0.ne_blocks_per_frame, 4);
      end
      if (k == 11) begin start0 = 1'b1; cfg0 = 32'd7; end
      if (k == 12) begin start0 = 1'b0; cfg0 = 32'd0; end
      if (k == 13) check("busy_start_blocks", bus0.ne_blocks_per_frame, 4);
      if (k == 18) begin
        bus0.ne_estimated_noise = 16'h1234; bus0.ne_estimated_noise_ready = 1'b1;
      end
      if (k == 19) begin
        bus0.ne_estimated_noise = 16'h0; bus0.ne_estimated_noise_ready = 1'b0;
      end
      if (k == 20) check("early_ready_noise", noise0, 0);
      if (k == 31) begin
        bus0.ne_estimated_noise = 16'h0050; bus0.ne_estimated_noise_ready = 1'b1;
      end
      if (k == 32) begin
        bus0.ne_estimated_noise = 16'h0; bus0.ne_estimated_noise_ready = 1'b0;
        check("nom_noise", noise0, 16'h0050);
      end
      if (k == 33) check("nom_noise_held", noise0, 16'h0050);
    end

    // Reset during block 1 sample 2, then a fresh 1-block frame.
    for (int i = 0; i < 7; i++) begin
      exp_addr0.push_back(16'(i));
      exp_data0.push_back(8'(4 * i));
    end
    start0 = 1'b1; cfg0 = 32'd4;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (k == 1) start0 = 1'b0;
      check("pre_rst_rd_en", bus0.mem_rd_en, exp_rd(k, 4));
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", busy0, 0);
    check("mid_rst_rd_en", bus0.mem_rd_en, 0);
    check("mid_rst_addr", bus0.mem_addr, 0);
    check("mid_rst_sd", bus0.ne_start_data, 0);
    check("mid_rst_blocks", bus0.ne_blocks_per_frame, 0);
    check("mid_rst_noise", noise0, 0);
    check("mid_rst_done", done0, 0);
    check("mid_rst_state", dbg0, 0);
    @(negedge clk);
    check("post_rst_done", done0, 0);
    check("post_rst_busy", busy0, 0);

    for (int i = 0; i < 4; i++) begin
      exp_addr0.push_back(16'(i));
      exp_data0.push_back(8'(4 * i));
    end
    start0 = 1'b1; cfg0 = 32'd1;
    for (int k = 1; k <= wait_cycle(1) + 2; k++) begin
      @(negedge clk);
      if (k == 1) start0 = 1'b0;
      check("one_rd_en", bus0.mem_rd_en, exp_rd(k, 1));
      check("one_sof", bus0.ne_start_of_frame, k == FIRST + 1);
      check("one_done", done0, k == wait_cycle(1) + 1);
      check("one_nv", nv0, k == wait_cycle(1) + 1);
      if (k == wait_cycle(1)) begin
        bus0.ne_estimated_noise = 16'h00a5; bus0.ne_estimated_noise_ready = 1'b1;
      end
      if (k == wait_cycle(1) + 1) begin
        bus0.ne_estimated_noise_ready = 1'b0;
        check("one_noise", noise0, 16'h00a5);
      end
    end

    // Address wrap on the 3-bit instance: 0..7 then 0..3.
    for (int i = 0; i < 12; i++) begin
      exp_addr1.push_back(16'(i % 8));
      exp_data1.push_back(8'(4 * (i % 8)));
    end
    start1 = 1'b1; cfg1 = 32'd3;
    for (int k = 1; k <= wait_cycle(3) + 2; k++) begin
      @(negedge clk);
      if (k == 1) start1 = 1'b0;
      check("wrap_rd_en", bus1.mem_rd_en, exp_rd(k, 3));
      check("wrap_done", done1, k == wait_cycle(3) + 1);
      if (k == wait_cycle(3)) begin
        bus1.ne_estimated_noise = 16'h0777; bus1.ne_estimated_noise_ready = 1'b1;
      end
      if (k == wait_cycle(3) + 1) begin
        bus1.ne_estimated_noise_ready = 1'b0;
        check("wrap_nv", nv1, 1);
        check("wrap_noise", noise1, 16'h0777);
      end
    end

    @(negedge clk);
    check("addr0_left", exp_addr0.size(), 0);
    check("data0_left", exp_data0.size(), 0);
    check("addr1_left", exp_addr1.size(), 0);
    check("data1_left", exp_data1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/noise_est_frame_sequencer.md
Name: noise_est_frame_sequencer

Overview:
- Frame-level controller that drives the noise_estimation datapath.
- On a host start pulse it reads one frame of pixels from a block-organised pixel memory, block by block.
- It generates the estimator's start_of_frame / start_data framing with a programmable inter-block gap, waits for the estimator's result, then returns the noise value to the host with a one-cycle valid strobe.

Parameters:
- DATA_WIDTH, 8, pixel width; estimator result is 2*DATA_WIDTH.
- TOTAL_SAMPLES, 64, samples per block; must be ≥2.
- ADDR_WIDTH, 16, pixel memory address width.
- BLOCK_GAP, 2, idle cycles before each block; must be ≥1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  host pulse: begin one frame
- cfg_blocks_per_frame  in  32  blocks in frame; sampled on accepted start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse, frame finished
- cfg_error  out  1  one-cycle pulse, start rejected because cfg_blocks_per_frame==0
- mem_rd_en  out  1  pixel memory read enable
- mem_addr  out  ADDR_WIDTH  pixel memory address
- mem_rd_data  in  DATA_WIDTH  read data, valid exactly 1 cycle after mem_rd_en
- ne_start_of_frame  out  1  to estimator
- ne_start_data  out  1  to estimator
- ne_data_in  out  DATA_WIDTH  to estimator; combinational pass-through of mem_rd_data
- ne_blocks_per_frame  out  32  latched config to estimator
- ne_estimated_noise  in  2*DATA_WIDTH  from estimator
- ne_estimated_noise_ready  in  1  from estimator
- noise_out  out  2*DATA_WIDTH  captured result; held until next capture
- noise_valid  out  1  one-cycle pulse with capture

Behaviour:
- Reset: all outputs 0, FSM = IDLE, counters 0. A rst mid-frame aborts immediately; no done pulse is issued.
- FSM states: IDLE, LOAD, GAP, STREAM, WAIT_RES, DONE.
- IDLE:
  - start && cfg_blocks_per_frame!=0 → LOAD.
  - start && cfg_blocks_per_frame==0 → cfg_error pulse next cycle, stay IDLE.
- LOAD (1 cycle):
  - latch ne_blocks_per_frame; block_cnt=0; mem_addr=0; busy=1.
  - → GAP.
- GAP: gap_cnt counts BLOCK_GAP cycles, then → STREAM. All ne_* strobes are 0.
- STREAM: sample index s = 0..TOTAL_SAMPLES, so the state lasts TOTAL_SAMPLES+1 cycles.
  - s<TOTAL_SAMPLES: mem_rd_en=1; mem_addr increments by 1 after each read.
  - s==1: ne_start_data=1; ne_start_of_frame=1 only when block_cnt==0.
  - Beats at s=1..TOTAL_SAMPLES carry samples 0..TOTAL_SAMPLES-1 on ne_data_in.
  - At s==TOTAL_SAMPLES: block_cnt++. If block_cnt+1 < ne_blocks_per_frame → GAP, else → WAIT_RES.
- mem_addr for block b, sample k = b*TOTAL_SAMPLES+k, modulo 2^ADDR_WIDTH (silent wrap).
- WAIT_RES:
  - on ne_estimated_noise_ready: noise_out ← ne_estimated_noise, noise_valid pulse next cycle, → DONE.
  - ne_estimated_noise_ready in any other state is ignored.
- DONE (1 cycle): done=1, busy deasserts the following cycle, → IDLE.
- start while busy is ignored and does not alter the latched config.
- ne_estimated_noise_ready coinciding with rst: reset wins.
- Latency, start to first mem_rd_en: 2+BLOCK_GAP cycles.
- Counters: block_cnt is 32 bits; sample counter is $clog2(TOTAL_SAMPLES+1) bits.

Optional Feature:
- Macro NE_SEQ_TIMEOUT_EN.
- When defined:
  - adds parameter TIMEOUT_CYCLES (default 4096) and output timeout_err (1 bit).
  - a counter runs in WAIT_RES; if ready is not seen within TIMEOUT_CYCLES cycles, timeout_err pulses for 1 cycle and the FSM → DONE with noise_out unchanged and no noise_valid.
- When undefined: WAIT_RES waits indefinitely; no timeout_err port exists.

Test Plan (TOTAL_SAMPLES=4, BLOCK_GAP=2, memory word[a]=4*a):
- Nominal frame: start with cfg=4 → 16 reads at addresses 0..15; 4 ne_start_data pulses; one ne_start_of_frame, on block 0 only; ne_data_in sequence 0,4,...,60; after estimator ready with 0x0050 → noise_out=0x0050, noise_valid 1 cycle, then done 1 cycle.
- Gap/latency check: start at cycle 0 → first mem_rd_en at cycle 4; exactly 2 idle cycles between the last beat of each block and the next mem_rd_en.
- Zero config: start with cfg=0 → cfg_error 1 cycle, busy stays 0, no mem_rd_en.
- Start while busy, plus early ready: second start mid-frame with cfg=7 → ignored, ne_blocks_per_frame stays 4; ready pulsed during block 2 → ignored, capture happens only in WAIT_RES.
- Reset mid-STREAM: rst during block 1 sample 2 → all outputs 0 next cycle, no done; a new start with cfg=1 → addresses 0..3.
- Address wrap: ADDR_WIDTH=3, cfg=3 → addresses 0..7 then 0..3.
- Timeout (macro defined, TIMEOUT_CYCLES=10): no ready → timeout_err at the 10th WAIT_RES cycle, done follows, noise_valid never asserted.
